// File: rtl/mem_loader_pkg.sv
// rtl/mem_loader_pkg.sv - shared types and constants for the flash image loader
package mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_LEN,
        RX_WORD,
        WRITE,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles little-endian bytes into one word
module byte_word_packer
    import mem_loader_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       in_data,
    output logic [WIDTH-1:0] word,
    output logic             word_complete
);

    logic [1:0]       byte_cnt;
    logic [WIDTH-1:0] shift_reg;

    // Bytes enter at the top and shift down, so after four shifts byte 0 sits in [7:0].
    // word already includes the byte being accepted this cycle.
    assign word          = {in_data, shift_reg[WIDTH-1:8]};
    assign word_complete = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (clear) begin
            byte_cnt  <= '0;
        end else if (accept) begin
            byte_cnt  <= byte_cnt + 2'd1;
            shift_reg <= word;
        end
    end

endmodule

// File: rtl/mem_flash_loader.sv
// rtl/mem_flash_loader.sv - streams a length-prefixed byte image into the memory flash port
module mem_flash_loader
    import mem_loader_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  flash_en,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    output logic [WIDTH-1:0]      flash_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int IDXW = $clog2(MAX_WORDS + 1);

    loader_state_t   state, state_next;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] n_words;
    logic [IDXW-1:0] idx_inc;
    logic [WIDTH-1:0] word;
    logic            word_complete;
    logic            accept;
    logic            start_load;

    assign in_ready   = (state == RX_LEN) || (state == RX_WORD);
    assign accept     = in_valid && in_ready;
    assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign idx_inc    = idx + IDXW'(1);

    byte_word_packer #(.WIDTH(WIDTH)) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_load),
        .accept        (accept),
        .in_data       (in_data),
        .word          (word),
        .word_complete (word_complete)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = RX_LEN;
            end
            RX_LEN: begin
                busy = 1'b1;
                if (word_complete) begin
                    if (word == '0)                         state_next = DONE;
                    else if (word > WIDTH'(MAX_WORDS))      state_next = ERROR;
                    else                                    state_next = RX_WORD;
                end
            end
            RX_WORD: begin
                busy = 1'b1;
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                state_next = (idx_inc == n_words) ? DONE : RX_WORD;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = RX_LEN;
            end
            ERROR: begin
                error = 1'b1;
                if (start) state_next = RX_LEN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Flash outputs are loaded on the edge that takes the last byte, so the strobe lines up
    // exactly with the WRITE state; address and data hold between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            n_words    <= '0;
            flash_en   <= 1'b0;
            flash_addr <= '0;
            flash_data <= '0;
        end else begin
            flash_en <= 1'b0;
            if (start_load) begin
                idx <= '0;
            end
            if ((state == RX_LEN) && word_complete) begin
                n_words <= word[IDXW-1:0];
            end
            if ((state == RX_WORD) && word_complete) begin
                flash_en   <= 1'b1;
                flash_addr <= ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(idx) << 2);
                flash_data <= word;
            end
            if (state == WRITE) begin
                idx <= idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_mem_flash_loader.sv
// tb/tb_mem_flash_loader.sv - scoreboard bench for mem_flash_loader
module tb_mem_flash_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        flash_en;
    logic [31:0] flash_addr;
    logic [31:0] flash_data;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;
    int n_writes = 0;
    int rdy_low = 0;
    logic prev_en = 1'b0;
    logic [31:0] mem [0:15];
    logic [63:0] sb_q [$];

    always #5 clk = ~clk;

    mem_flash_loader #(
        .WIDTH      (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (0),
        .MAX_WORDS  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flash_en   (flash_en),
        .flash_addr (flash_addr),
        .flash_data (flash_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_en <= 1'b0;
        end else begin
            if (busy && !in_ready) rdy_low <= rdy_low + 1;
            if (flash_en) begin
                logic [63:0] e;
                check("flash_en_back_to_back", 64'(prev_en), 64'd0);
                check("in_ready_during_write", 64'(in_ready), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_write", {flash_addr, flash_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("write_addr", 64'(flash_addr), 64'(e[63:32]));
                    check("write_data", 64'(flash_data), 64'(e[31:0]));
                end
                mem[flash_addr[5:2]] <= flash_data;
                n_writes <= n_writes + 1;
            end
            prev_en <= flash_en;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        bit   ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || error) begin
                ok = 1;
                break;
            end
        end
        check(tag, 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_flash_en", 64'(flash_en), 64'd0);
        check("rst_busy_done_error", {61'd0, busy, done, error}, 64'd0);
        check("rst_addr_data", {flash_addr, flash_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: two-word image
        pulse_start();
        send_word(32'd2, 0);
        expect_write(32'd0, 32'd12345);
        send_word(32'h0000_3039, 0);
        expect_write(32'd4, 32'd678910);
        send_word(32'h000A_5BFE, 0);
        wait_done("t1_done_wait");
        check("t1_done", 64'(done), 64'd1);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_mem0", 64'(mem[0]), 64'd12345);
        check("t1_mem1", 64'(mem[1]), 64'd678910);
        check("t1_sb_empty", 64'(sb_q.size()), 64'd0);

        // 2: empty image, done the cycle right after the 4th count byte
        w0 = n_writes;
        pulse_start();
        send_word(32'd0, 0);
        check("t2_done_next_cycle", 64'(done), 64'd1);
        check("t2_no_write", 64'(n_writes), 64'(w0));

        // 3: count above MAX_WORDS, then recover with a valid one-word image
        pulse_start();
        send_word(32'd5, 0);
        check("t3_error", 64'(error), 64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_no_write", 64'(n_writes), 64'(w0));
        pulse_start();
        send_word(32'd1, 0);
        expect_write(32'd0, 32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF, 0);
        wait_done("t3_done_wait");
        check("t3_done", 64'(done), 64'd1);
        check("t3_error_clear", 64'(error), 64'd0);

        // 4: three-cycle gaps between bytes; in_ready drops only in the write cycle
        pulse_start();
        rdy_low = 0;
        send_word(32'd1, 3);
        expect_write(32'd0, 32'hA5C3_0F71);
        send_word(32'hA5C3_0F71, 3);
        wait_done("t4_done_wait");
        check("t4_ready_low_cycles", 64'(rdy_low), 64'd1);
        check("t4_sb_empty", 64'(sb_q.size()), 64'd0);

        // 5: reset in the middle of word 1
        w0 = n_writes;
        pulse_start();
        send_word(32'd3, 0);
        expect_write(32'd0, 32'h1111_2222);
        send_word(32'h1111_2222, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        rst = 1'b1;
        #1;
        check("t5_rst_outputs", {flash_addr, flash_data}, 64'd0);
        check("t5_rst_flags", {59'd0, in_ready, flash_en, busy, done, error}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_one_write", 64'(n_writes), 64'(w0 + 1));
        pulse_start();
        send_word(32'd1, 0);
        expect_write(32'd0, 32'h7777_8888);
        send_word(32'h7777_8888, 0);
        wait_done("t5_done_wait");
        check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

        // 6: start during RX_WORD has no effect
        pulse_start();
        send_word(32'd2, 0);
        expect_write(32'd0, 32'h0102_0304);
        send_byte(8'h04, 0);
        send_byte(8'h03, 0);
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        expect_write(32'd4, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D, 0);
        wait_done("t6_done_wait");
        check("t6_done", 64'(done), 64'd1);
        check("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
